farbborg_pwm_scan: RTL and testbench
====================================

# farbborg_pwm_scan

Frame-buffer scanner and PWM generator for the LED cube. It reads 64-bit words from port B of the 1024-byte frame RAM (8 brightness bytes per word) and compares each byte against a running PWM level. The results are serialised into 8 parallel LED shift-register chains, and the block sequences latch, output-enable and plane-select so that one cube plane is lit at a time.

## Interface
Parameters:
- PLANES, 16: number of planes scanned, 1..16; plane p occupies RAM words p*8..p*8+7.
- PWM_MAX, 254: highest PWM level; levels 0..PWM_MAX form one PWM period.
- BLANK_CYC, 4: dead cycles inserted at every plane change, 0..255.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  scan enable, level.
- ram_addr_o  out  7  RAM port-B word address, {plane[3:0], word[2:0]}.
- ram_data_i  in  64  RAM port-B data. Registered read: valid 1 cycle after the address is presented.
- sdata_o  out  8  serial data; bit k drives chain k.
- sclk_o  out  1  shift clock to the chains.
- latch_o  out  1  one-cycle latch strobe to the chains.
- oe_n_o  out  1  LED output enable, active-low.
- plane_o  out  4  plane-driver select.
- frame_o  out  1  one-cycle pulse at every plane wrap (PLANES-1 to 0), used upstream for buffer swap.

## Operation
- **Byte mapping:** ram_data_i[8k+7:8k] is the brightness of chain k. The compare bit is 1 when byte > pwm (unsigned, 8-bit), so byte 0 is always off and byte 255 is always on.
- **Counters:**
  - word: 3 bits, 0..7.
  - pwm: 8 bits, 0..PWM_MAX.
  - plane: 4 bits, 0..PLANES-1.
- **States:** IDLE, ADDR, DATA, SETUP, CLK, LATCH, BLANK.
- **IDLE:**
  - Outputs: oe_n_o=1; sclk_o, latch_o and frame_o are 0.
  - Transition: when en_i=1, go to ADDR with word=0, pwm=0, plane=0, and plane_o=0.
- **Per-word sequence (ADDR → DATA → SETUP → CLK):**
  - ADDR: ram_addr_o={plane,word} is held.
  - DATA: ram_data_i is valid; sdata_o is registered from the 8 compare bits.
  - SETUP: sdata_o is stable and sclk_o=0.
  - CLK: sclk_o=1 and sdata_o is unchanged; word increments. If word was 7, go to LATCH; otherwise go to ADDR.
- **LATCH:**
  - latch_o=1 for this single cycle.
  - If this is the first latch since a plane change or start: oe_n_o goes to 0 on the cycle after LATCH.
  - If pwm<PWM_MAX: pwm increments, then go to ADDR.
  - If pwm=PWM_MAX: pwm=0, oe_n_o=1, plane increments (wrapping at PLANES-1 to 0), plane_o updates, frame_o pulses on a wrap, then go to BLANK.
- **BLANK:** lasts BLANK_CYC cycles with oe_n_o=1, then go to ADDR. With BLANK_CYC=0, go straight to ADDR. oe_n_o stays 1 through the first PWM step of the new plane (anti-ghosting) and falls only after that step's LATCH.
- **en_i:**
  - Sampled only in LATCH. If en_i=0 there, go to IDLE and set oe_n_o=1 on the next cycle.
  - An en_i drop mid-step completes the current step, including its latch.
- **Reset mid-operation:** all state is cleared immediately and the block returns to IDLE; no partial shift is completed.

## Timing
- **Reset values:** ram_addr_o=0, sdata_o=0, sclk_o=0, latch_o=0, oe_n_o=1, plane_o=0, frame_o=0. All outputs are registered.
- **Step and period lengths:**
  - One word: 4 cycles.
  - One PWM step: 8*4+1 = 33 cycles.
  - One plane: (PWM_MAX+1)*33 + BLANK_CYC cycles; 8419 with defaults.
  - One frame: PLANES × the plane time; 134704 with defaults.
- **sclk_o:** high exactly 1 cycle, with sdata_o stable 1 cycle before, during, and 1 cycle after the high phase.
- **latch_o:** one cycle after the 8th sclk_o pulse of a step. There are never two latch_o pulses fewer than 33 cycles apart.
- **First word:** ram_addr_o for word 0 of step 0 is presented on the first cycle after leaving IDLE or BLANK.
- **frame_o:** asserted in the same cycle that plane_o changes to 0.

## Test plan
- **Reset and start:** assert rst_i mid-step → all outputs take their reset values asynchronously. Release, set en_i=1 → first ram_addr_o=0x00, and the first latch_o comes 33 cycles after leaving IDLE.
- **Extremes:** RAM all 0x00 → sdata_o=0x00 on every shift. RAM all 0xFF → sdata_o=0xFF on every shift at every pwm level.
- **Duty cycle:** chain 3 of plane 0 holds byte 0x80 (word 0, bits 31:24) → sdata_o[3] is 1 for pwm 0..127 and 0 for pwm 128..254, i.e. 128 of 255 steps.
- **Plane change:** after the 255th latch of plane 0 → oe_n_o=1, plane_o=1, then 4 BLANK cycles. oe_n_o falls only after the first latch of plane 1; addresses then run 0x08..0x0F.
- **Frame wrap:** PLANES=2, PWM_MAX=3 → frame_o pulses once every 2*(4*33+4)=272 cycles, coincident with plane_o changing to 0.
- **Disable:** drop en_i during word 5 → the step completes (sclk_o pulses for words 5..7, then latch_o), then IDLE with oe_n_o=1. No further sclk_o pulses.

Source files
------------

// File: rtl/farbborg_pwm_scan.sv
// farbborg_pwm_scan: frame-buffer scanner and PWM generator for the LED cube.
// Reads one 64-bit word (8 brightness bytes) per 4-cycle slot and compares each
// byte against the running PWM level. It shifts the 8 compare bits into 8
// parallel chains, then latches the chains and drives output-enable and plane
// select, so that only one plane is lit at a time.
module farbborg_pwm_scan #(
    parameter int PLANES    = 16,
    parameter int PWM_MAX   = 254,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [6:0]  ram_addr_o,
    input  logic [63:0] ram_data_i,
    output logic [7:0]  sdata_o,
    output logic        sclk_o,
    output logic        latch_o,
    output logic        oe_n_o,
    output logic [3:0]  plane_o,
    output logic        frame_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        SETUP,
        CLK,
        LATCH,
        BLANK
    } state_t;

    localparam logic [3:0] PLANE_LAST = 4'(PLANES - 1);
    localparam logic [7:0] PWM_LAST   = 8'(PWM_MAX);
    localparam logic [7:0] BLANK_LAST = 8'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t     state_q, state_d;
    logic [2:0] word_q, word_d;
    logic [7:0] pwm_q, pwm_d;
    logic [3:0] plane_q, plane_d;
    logic [7:0] blank_q, blank_d;
    logic [7:0] sdata_q, sdata_d;
    logic       sclk_q, sclk_d;
    logic       latch_q, latch_d;
    logic       oe_n_q, oe_n_d;
    logic       frame_q, frame_d;
    logic [7:0] cmp;

    // The address is the live {plane, word} counter pair, so it is already
    // valid in the first ADDR cycle and holds through DATA for the
    // registered RAM read.
    assign ram_addr_o = {plane_q, word_q};
    assign plane_o    = plane_q;
    assign sdata_o    = sdata_q;
    assign sclk_o     = sclk_q;
    assign latch_o    = latch_q;
    assign oe_n_o     = oe_n_q;
    assign frame_o    = frame_q;

    // Per-chain compare: a byte lights its LED while it exceeds the PWM level.
    always_comb begin
        cmp = '0;
        for (int k = 0; k < 8; k++) begin
            cmp[k] = (ram_data_i[8*k +: 8] > pwm_q);
        end
    end

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves
        // one unassigned and no latch is inferred.
        state_d = state_q;
        word_d  = word_q;
        pwm_d   = pwm_q;
        plane_d = plane_q;
        blank_d = blank_q;
        sdata_d = sdata_q;
        oe_n_d  = oe_n_q;
        frame_d = 1'b0;

        case (state_q)
            IDLE: begin
                oe_n_d = 1'b1;
                if (en_i) begin
                    state_d = ADDR;
                    word_d  = 3'd0;
                    pwm_d   = 8'd0;
                    plane_d = 4'd0;
                end
            end
            ADDR:  state_d = DATA;
            DATA: begin
                sdata_d = cmp;
                state_d = SETUP;
            end
            SETUP: state_d = CLK;
            CLK: begin
                word_d  = word_q + 3'd1;
                state_d = (word_q == 3'd7) ? LATCH : ADDR;
            end
            LATCH: begin
                if (!en_i) begin
                    state_d = IDLE;
                    oe_n_d  = 1'b1;
                end else if (pwm_q != PWM_LAST) begin
                    // Within a plane the LEDs are lit once the first step has
                    // been latched; this keeps the previous plane's data dark.
                    pwm_d   = pwm_q + 8'd1;
                    oe_n_d  = 1'b0;
                    state_d = ADDR;
                end else begin
                    pwm_d  = 8'd0;
                    oe_n_d = 1'b1;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = 4'd0;
                        frame_d = 1'b1;
                    end else begin
                        plane_d = plane_q + 4'd1;
                    end
                    if (BLANK_CYC == 0) begin
                        state_d = ADDR;
                    end else begin
                        state_d = BLANK;
                        blank_d = BLANK_LAST;
                    end
                end
            end
            BLANK: begin
                if (blank_q == 8'd0) begin
                    state_d = ADDR;
                end else begin
                    blank_d = blank_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        sclk_d  = (state_d == CLK);
        latch_d = (state_d == LATCH);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= 3'd0;
            pwm_q   <= 8'd0;
            plane_q <= 4'd0;
            blank_q <= 8'd0;
            sdata_q <= 8'd0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            oe_n_q  <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            word_q  <= word_d;
            pwm_q   <= pwm_d;
            plane_q <= plane_d;
            blank_q <= blank_d;
            sdata_q <= sdata_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            oe_n_q  <= oe_n_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: tb/tb_farbborg_pwm_scan.sv
// Self-checking bench for farbborg_pwm_scan. Instance a uses the default sizes
// and is checked event-by-event against a queue of expected shifts and latches.
// Instance b is reduced to 2 planes x 4 PWM levels to exercise frame wrap.
module tb_farbborg_pwm_scan;

    localparam int PLANES_A  = 16;
    localparam int PWM_MAX_A = 254;
    localparam int BLANK_A   = 4;
    localparam int PLANES_B  = 2;
    localparam int PWM_MAX_B = 3;
    localparam int BLANK_B   = 4;
    localparam int FRAME_B   = PLANES_B * ((PWM_MAX_B + 1) * 33 + BLANK_B);

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [6:0]  addr_a, addr_b;
    logic [63:0] rdata_a, rdata_b;
    logic [7:0]  sdata_a, sdata_b;
    logic        sclk_a, sclk_b, latch_a, latch_b, oe_n_a, oe_n_b, frame_a, frame_b;
    logic [3:0]  plane_a, plane_b;

    always #5 clk = ~clk;

    farbborg_pwm_scan #(.PLANES(PLANES_A), .PWM_MAX(PWM_MAX_A), .BLANK_CYC(BLANK_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en_a), .ram_addr_o(addr_a), .ram_data_i(rdata_a),
        .sdata_o(sdata_a), .sclk_o(sclk_a), .latch_o(latch_a), .oe_n_o(oe_n_a),
        .plane_o(plane_a), .frame_o(frame_a));

    farbborg_pwm_scan #(.PLANES(PLANES_B), .PWM_MAX(PWM_MAX_B), .BLANK_CYC(BLANK_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .ram_addr_o(addr_b), .ram_data_i(rdata_b),
        .sdata_o(sdata_b), .sclk_o(sclk_b), .latch_o(latch_b), .oe_n_o(oe_n_b),
        .plane_o(plane_b), .frame_o(frame_b));

    // Frame RAM models with a registered read port.
    logic [63:0] mem_a [0:127];
    always @(posedge clk) rdata_a <= mem_a[addr_a];
    always @(posedge clk) rdata_b <= {8{1'b0, addr_b}};

    typedef struct {
        bit         is_latch;
        logic [6:0] addr;
        logic [7:0] data;
        logic [3:0] plane;
        logic       oe_n;
        logic       oe_after;
        int         gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run starts at plane 0, level 0 and walks the steps in
    // order. Each step shifts the 8 words of its plane and then latches.
    task automatic push_run(input int nsteps);
        ev_t         e;
        int          pwm, pl;
        logic [63:0] word;
        for (int s = 0; s < nsteps; s++) begin
            pwm = s % (PWM_MAX_A + 1);
            pl  = (s / (PWM_MAX_A + 1)) % PLANES_A;
            for (int w = 0; w < 8; w++) begin
                word       = mem_a[pl*8 + w];
                e.is_latch = 0;
                e.addr     = 7'(pl*8 + w);
                for (int k = 0; k < 8; k++) e.data[k] = (int'(word[8*k +: 8]) > pwm);
                e.plane    = 4'(pl);
                e.oe_n     = (pwm == 0);
                e.oe_after = 1'b0;
                e.gap      = (w != 0) ? 4 : (s == 0) ? 0 : (pwm == 0) ? 4 + BLANK_A : 4;
                exp_q.push_back(e);
            end
            e.is_latch = 1;
            e.addr     = '0;
            e.data     = '0;
            e.plane    = 4'(pl);
            e.oe_n     = (pwm == 0);
            e.oe_after = (s == nsteps - 1) || (pwm == PWM_MAX_A);
            e.gap      = 1;
            exp_q.push_back(e);
        end
    endtask

    // Cycle counter and monitor for instance a.
    int   cyc = 0;
    int   last_cyc = 0;
    bit   mon_on = 0;
    bit   pend_oe = 0;
    logic pend_oe_val = 1'b1;
    int   sclk_cnt = 0, latch_cnt = 0;
    bit   duty_on = 0;
    int   duty_ones = 0, duty_tot = 0;
    ev_t  mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pend_oe) begin
            check("oe_n_after_latch", oe_n_a, pend_oe_val);
            check("frame_a_after_latch", frame_a, 1'b0);
            pend_oe = 0;
        end
        if (latch_a) check("sclk_during_latch", sclk_a, 1'b0);
        if (sclk_a) sclk_cnt++;
        if (latch_a) latch_cnt++;
        if (duty_on && sclk_a && addr_a == 7'd0) begin
            duty_tot++;
            duty_ones += int'(sdata_a[3]);
        end
        if (mon_on && (sclk_a || latch_a)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {sclk_a, latch_a}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", latch_a, mon_e.is_latch);
                if (mon_e.gap != 0) check("event_gap", cyc - last_cyc, mon_e.gap);
                check("plane", plane_a, mon_e.plane);
                check("oe_n", oe_n_a, mon_e.oe_n);
                if (!mon_e.is_latch) begin
                    check("addr", addr_a, mon_e.addr);
                    check("sdata", sdata_a, mon_e.data);
                end else begin
                    pend_oe     = 1;
                    pend_oe_val = mon_e.oe_after;
                end
            end
            last_cyc = cyc;
        end
    end

    // Frame monitor for instance b.
    int frame_cnt_b = 0;
    int last_frame_b = -1;

    always @(negedge clk) begin
        if (latch_b) check("b_sclk_during_latch", sclk_b, 1'b0);
        if (frame_b) begin
            check("frame_plane", plane_b, 4'd0);
            check("frame_oe_n", oe_n_b, 1'b1);
            if (last_frame_b >= 0) check("frame_interval", cyc - last_frame_b, FRAME_B);
            last_frame_b = cyc;
            frame_cnt_b++;
        end
    end

    task automatic fill_mem(input logic [63:0] v);
        for (int i = 0; i < 128; i++) mem_a[i] = v;
    endtask

    // Enable, let nsteps run, drop en_i inside word 5 of the last step, and
    // confirm the block stops cleanly after that step's latch.
    task automatic run_and_stop(input int nsteps, input int budget);
        int sclk0, latch0, sc;
        bit hit;
        sclk0 = sclk_cnt;
        latch0 = latch_cnt;
        push_run(nsteps);
        mon_on = 1;
        @(negedge clk);
        en_a = 1'b1;
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sclk_cnt - sclk0 >= (nsteps - 1) * 8 + 5) begin
                hit = 1;
                break;
            end
        end
        check("reach_last_word5", hit, 1'b1);
        @(negedge clk);
        en_a = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (latch_cnt - latch0 >= nsteps) begin
                hit = 1;
                break;
            end
        end
        check("steps_latched", latch_cnt - latch0, nsteps);
        repeat (2) @(negedge clk);
        check("oe_n_idle", oe_n_a, 1'b1);
        sc = sclk_cnt;
        repeat (40) @(negedge clk);
        check("no_shift_after_stop", sclk_cnt, sc);
        check("queue_drained", exp_q.size(), 0);
        mon_on = 0;
        exp_q.delete();
    endtask

    initial begin
        int   n, sc;
        logic [7:0] b;
        rst  = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        fill_mem('1);
        #2 rst = 1'b1;
        #3;
        check("rst_addr", addr_a, 7'd0);
        check("rst_sdata", sdata_a, 8'd0);
        check("rst_sclk", sclk_a, 1'b0);
        check("rst_latch", latch_a, 1'b0);
        check("rst_oe_n", oe_n_a, 1'b1);
        check("rst_plane", plane_a, 4'd0);
        check("rst_frame", frame_a, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Start-up latency: first address on the first cycle, first latch at 33.
        @(negedge clk);
        en_a = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("first_addr", addr_a, 7'h00);
                check("first_sclk", sclk_a, 1'b0);
            end
            if (latch_a) break;
        end
        check("first_latch_cycles", n, 33);

        // Asynchronous reset in the middle of a step.
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_addr", addr_a, 7'd0);
        check("rst_mid_sdata", sdata_a, 8'd0);
        check("rst_mid_sclk", sclk_a, 1'b0);
        check("rst_mid_latch", latch_a, 1'b0);
        check("rst_mid_oe_n", oe_n_a, 1'b1);
        check("rst_mid_plane", plane_a, 4'd0);
        check("rst_mid_frame", frame_a, 1'b0);
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sc = sclk_cnt;
        repeat (20) @(negedge clk);
        check("no_shift_after_reset", sclk_cnt, sc);
        check("oe_n_after_reset", oe_n_a, 1'b1);

        // All-dark RAM, with a disable during the last step.
        fill_mem('0);
        run_and_stop(3, 200);

        // Random RAM over a full plane and into the next one.
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 7))
                    0: b = 8'h00;
                    1: b = 8'hFF;
                    default: b = mem_a[i][8*k +: 8];
                endcase
                mem_a[i][8*k +: 8] = b;
            end
        end
        mem_a[0][31:24] = 8'h80;
        mem_a[1] = '1;
        mem_a[2] = '0;
        duty_ones = 0;
        duty_tot = 0;
        duty_on = 1;
        run_and_stop(PWM_MAX_A + 1 + 3, 9000);
        duty_on = 0;
        check("duty_chain3_steps", duty_tot, 255);
        check("duty_chain3_ones", duty_ones, 128);

        // Frame wrap on the reduced instance.
        @(negedge clk);
        en_b = 1'b1;
        repeat (1000) @(negedge clk);
        check("frames_seen", frame_cnt_b, 3);
        en_b = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
